// File: rtl/ce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ce_pkg
//  Description : Shared definitions for the channel-estimate block normalizer:
//                FSM state encoding, shift limit helper and error codes.
//  Revision    : 1.0  initial release
// ============================================================================
package ce_pkg;

    // FSM state encoding (2 bits, explicit values)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } ce_state_t;

    // Frame status codes reported on source_error
    localparam logic [1:0] c_ERR_NONE  = 2'b00;
    localparam logic [1:0] c_ERR_TRUNC = 2'b01;

    // Default sample width and the shift limit that goes with it
    localparam int c_WDATA_DEFAULT = 16;
    localparam int c_SHIFT_MAX     = c_WDATA_DEFAULT - 1;

    // Largest useful left shift for a given sample width: one sign bit must stay
    function automatic int shift_max(input int wdata);
        return wdata - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ce_frame_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ce_frame_ram
//  Description : Simple dual-port frame buffer, one write port, one read port
//                with a registered output. The output register only updates
//                when a read is issued, so it holds its word otherwise.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write address
//                i_wdata  - write data
//                i_re     - read enable
//                i_raddr  - read address
//                o_rdata  - registered read data (1-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module ce_frame_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ce_block_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : ce_block_normalize
//  Description : Block-floating-point normalizer. Buffers one complex frame,
//                tracks the smallest number of redundant sign bits over all
//                real/imag samples, then replays the frame shifted left by
//                that amount. Single-buffered: input stalls while draining.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                sink_valid/ready/sop/eop   - input stream handshake/framing
//                sink_real/imag, fftpts_in  - input sample and frame tag
//                source_valid/ready/sop/eop - output stream handshake/framing
//                source_real/imag           - normalized sample
//                source_error               - 00 normal, 01 truncated frame
//                source_exp                 - shift applied to the frame
//                fftpts_out                 - tag captured with the frame sop
//  Revision    : 1.0  initial release
// ============================================================================
module ce_block_normalize
    import ce_pkg::*;
#(
    parameter int wData = 16,
    parameter int wAddr = 11,
    parameter int wExp  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sink_valid,
    output logic             sink_ready,
    input  logic             sink_sop,
    input  logic             sink_eop,
    input  logic [wData-1:0] sink_real,
    input  logic [wData-1:0] sink_imag,
    input  logic [11:0]      fftpts_in,
    output logic             source_valid,
    input  logic             source_ready,
    output logic             source_sop,
    output logic             source_eop,
    output logic [wData-1:0] source_real,
    output logic [wData-1:0] source_imag,
    output logic [1:0]       source_error,
    output logic [wExp-1:0]  source_exp,
    output logic [11:0]      fftpts_out
);

    localparam logic [wExp-1:0]  c_SHIFT_LIMIT = wExp'(shift_max(wData));
    localparam logic [wAddr-1:0] c_ONE         = 1;

    // Redundant sign bits: leading bits equal to the MSB, minus the MSB itself
    function automatic logic [wExp-1:0] f_rsb(input logic [wData-1:0] v);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = wData - 2; i >= 0; i--) begin
            if (run && (v[i] == v[wData-1])) begin
                n++;
            end else begin
                run = 1'b0;
            end
        end
        return n[wExp-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    ce_state_t         r_state;
    logic              r_sink_ready;
    logic [wAddr-1:0]  r_cnt;        // next write address within the frame
    logic [wAddr-1:0]  r_last;       // address of the last stored sample
    logic [wExp-1:0]   r_shift;      // running minimum of redundant bits
    logic [1:0]        r_err_frame;
    logic [11:0]       r_fftpts;
    logic [wAddr-1:0]  r_rd_addr;    // next address to read
    logic [wAddr-1:0]  r_pend_addr;  // address of the word held in RAM output
    logic              r_rd_done;    // every address of the frame has been read
    logic              r_rd_pend;    // RAM output holds a word not yet presented

    logic              r_src_valid;
    logic              r_src_sop;
    logic              r_src_eop;
    logic [wData-1:0]  r_src_real;
    logic [wData-1:0]  r_src_imag;
    logic [1:0]        r_src_err;
    logic [wExp-1:0]   r_src_exp;
    logic [11:0]       r_src_pts;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_start;
    logic                w_in_frame;
    logic [wAddr-1:0]    w_wr_addr;
    logic                w_trunc;
    logic                w_last;
    logic [wExp-1:0]     w_r_re;
    logic [wExp-1:0]     w_r_im;
    logic [wExp-1:0]     w_shift_nxt;
    logic                w_load;
    logic                w_issue;
    logic                w_out_done;
    logic [2*wData-1:0]  w_rd_data;

    assign w_accept   = sink_valid & r_sink_ready;
    assign w_start    = w_accept & sink_sop;
    // A sample without sop only belongs to a frame while filling
    assign w_in_frame = w_accept & (w_start | (r_state == ST_FILL));
    assign w_wr_addr  = w_start ? '0 : r_cnt;
    // Last buffer slot without eop closes the frame as truncated
    assign w_trunc    = w_in_frame & ~sink_eop & (w_wr_addr == '1);
    assign w_last     = w_in_frame & (sink_eop | w_trunc);

    assign w_r_re     = f_rsb(sink_real);
    assign w_r_im     = f_rsb(sink_imag);

    always_comb begin
        w_shift_nxt = w_start ? c_SHIFT_LIMIT : r_shift;
        if (w_r_re < w_shift_nxt) begin
            w_shift_nxt = w_r_re;
        end
        if (w_r_im < w_shift_nxt) begin
            w_shift_nxt = w_r_im;
        end
    end

    // The RAM output register doubles as a one-word skid buffer: a new read
    // is only issued when the word it holds is being consumed or is stale.
    assign w_load     = r_rd_pend & (~r_src_valid | source_ready);
    assign w_issue    = (r_state == ST_DRAIN) & ~r_rd_done & (~r_rd_pend | w_load);
    assign w_out_done = r_src_valid & source_ready & r_src_eop;

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    ce_frame_ram #(
        .DATA_W (2 * wData),
        .ADDR_W (wAddr)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_in_frame),
        .i_waddr (w_wr_addr),
        .i_wdata ({sink_real, sink_imag}),
        .i_re    (w_issue),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rd_data)
    );

    // ------------------------------------------------------------------
    // FSM: fill / drain control
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sink_ready <= 1'b0;
            r_cnt        <= '0;
            r_last       <= '0;
            r_shift      <= c_SHIFT_LIMIT;
            r_err_frame  <= c_ERR_NONE;
            r_fftpts     <= '0;
            r_rd_addr    <= '0;
            r_pend_addr  <= '0;
            r_rd_done    <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_FILL: begin
                    r_sink_ready <= 1'b1;
                    if (w_in_frame) begin
                        r_shift <= w_shift_nxt;
                        r_cnt   <= w_wr_addr + c_ONE;
                        if (w_start) begin
                            r_fftpts <= fftpts_in;
                        end
                        if (w_last) begin
                            r_state      <= ST_DRAIN;
                            r_sink_ready <= 1'b0;
                            r_last       <= w_wr_addr;
                            r_err_frame  <= w_trunc ? c_ERR_TRUNC : c_ERR_NONE;
                            r_rd_addr    <= '0;
                            r_rd_done    <= 1'b0;
                        end else begin
                            r_state <= ST_FILL;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_issue) begin
                        r_rd_addr   <= r_rd_addr + c_ONE;
                        r_pend_addr <= r_rd_addr;
                        if (r_rd_addr == r_last) begin
                            r_rd_done <= 1'b1;
                        end
                    end
                    if (w_out_done) begin
                        r_state      <= ST_IDLE;
                        r_sink_ready <= 1'b1;
                        r_cnt        <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend   <= 1'b0;
            r_src_valid <= 1'b0;
            r_src_sop   <= 1'b0;
            r_src_eop   <= 1'b0;
            r_src_real  <= '0;
            r_src_imag  <= '0;
            r_src_err   <= c_ERR_NONE;
            r_src_exp   <= '0;
            r_src_pts   <= '0;
        end else begin
            if (w_issue) begin
                r_rd_pend <= 1'b1;
            end else if (w_load) begin
                r_rd_pend <= 1'b0;
            end

            if (w_load) begin
                r_src_valid <= 1'b1;
                r_src_sop   <= (r_pend_addr == '0);
                r_src_eop   <= (r_pend_addr == r_last);
                // Shift never exceeds the redundant sign bits, so no overflow
                r_src_real  <= w_rd_data[2*wData-1:wData] << r_shift;
                r_src_imag  <= w_rd_data[wData-1:0] << r_shift;
                r_src_err   <= r_err_frame;
                r_src_exp   <= r_shift;
                r_src_pts   <= r_fftpts;
            end else if (source_ready) begin
                r_src_valid <= 1'b0;
                r_src_sop   <= 1'b0;
                r_src_eop   <= 1'b0;
            end
        end
    end

    assign sink_ready   = r_sink_ready;
    assign source_valid = r_src_valid;
    assign source_sop   = r_src_sop;
    assign source_eop   = r_src_eop;
    assign source_real  = r_src_real;
    assign source_imag  = r_src_imag;
    assign source_error = r_src_err;
    assign source_exp   = r_src_exp;
    assign fftpts_out   = r_src_pts;

endmodule
`default_nettype wire

// File: tb/tb_ce_block_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ce_block_normalize
//  Description : Directed self-checking bench for ce_block_normalize with
//                hand-computed expected frames.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ce_block_normalize;

    localparam int c_MAXP = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sink_valid = 1'b0;
    logic        sink_ready;
    logic        sink_sop = 1'b0;
    logic        sink_eop = 1'b0;
    logic [15:0] sink_real = '0;
    logic [15:0] sink_imag = '0;
    logic [11:0] fftpts_in = '0;
    logic        source_valid;
    logic        source_ready = 1'b1;
    logic        source_sop;
    logic        source_eop;
    logic [15:0] source_real;
    logic [15:0] source_imag;
    logic [1:0]  source_error;
    logic [3:0]  source_exp;
    logic [11:0] fftpts_out;

    ce_block_normalize #(
        .wData (16),
        .wAddr (11),
        .wExp  (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts_in    (fftpts_in),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_error (source_error),
        .source_exp   (source_exp),
        .fftpts_out   (fftpts_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] re;
        logic [15:0] im;
        logic [3:0]  ex;
        logic [1:0]  err;
        logic [11:0] pts;
    } out_t;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [15:0] re;
        logic [15:0] im;
    } in_t;

    out_t got_q[$];
    out_t exp_q[$];
    in_t  in_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    // Downstream ready: continuous, or the pattern 1,0,0,1,0,0,...
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            source_ready = (rdy_mode == 0) ? 1'b1 : ((cnt % 3) == 0);
            cnt++;
        end
    end

    // Output monitor: collect transfers, verify stability across stalls
    initial begin
        out_t cur;
        out_t prev;
        logic prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {source_sop, source_eop, source_real, source_imag,
                   source_exp, source_error, fftpts_out};
            if (rst_n && prev_stall) begin
                chk("stall_hold", {source_valid, cur}, {1'b1, prev});
            end
            if (rst_n && source_valid && source_ready) begin
                got_q.push_back(cur);
            end
            prev_stall = rst_n && source_valid && !source_ready;
            prev = cur;
        end
    end

    task automatic send_sample(input logic sop, input logic eop,
                               input logic [15:0] re, input logic [15:0] im,
                               input logic [11:0] pts);
        int t;
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_real  = re;
        sink_imag  = im;
        fftpts_in  = pts;
        t = 0;
        @(negedge clk);
        while (!sink_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            chk("sink_ready_wait", {63'd0, sink_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
    endtask

    task automatic send_all(input logic [11:0] pts);
        in_t s;
        while (in_q.size() > 0) begin
            s = in_q.pop_front();
            send_sample(s.sop, s.eop, s.re, s.im, pts);
        end
    endtask

    task automatic add_in(input logic sop, input logic eop,
                          input logic [15:0] re, input logic [15:0] im);
        in_t s;
        s.sop = sop; s.eop = eop; s.re = re; s.im = im;
        in_q.push_back(s);
    endtask

    task automatic add_exp(input logic sop, input logic eop,
                           input logic [15:0] re, input logic [15:0] im,
                           input logic [3:0] ex, input logic [1:0] err,
                           input logic [11:0] pts);
        out_t e;
        e.sop = sop; e.eop = eop; e.re = re; e.im = im;
        e.ex = ex; e.err = err; e.pts = pts;
        exp_q.push_back(e);
    endtask

    task automatic wait_n(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic check_frame(input string name);
        chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s_s%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
            end
        end
        chk({name, "_sink_ready_back"}, {63'd0, sink_ready}, 64'd1);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic frame_a_in();
        add_in(1'b1, 1'b0, 16'h0010, 16'h0000);
        add_in(1'b0, 1'b0, 16'hFFF0, 16'h0001);
        add_in(1'b0, 1'b0, 16'h0003, 16'hFFFC);
        add_in(1'b0, 1'b1, 16'h0000, 16'h0000);
    endtask

    task automatic frame_a_exp();
        add_exp(1'b1, 1'b0, 16'h4000, 16'h0000, 4'd10, 2'b00, 12'd4);
        add_exp(1'b0, 1'b0, 16'hC000, 16'h0400, 4'd10, 2'b00, 12'd4);
        add_exp(1'b0, 1'b0, 16'h0C00, 16'hF000, 4'd10, 2'b00, 12'd4);
        add_exp(1'b0, 1'b1, 16'h0000, 16'h0000, 4'd10, 2'b00, 12'd4);
    endtask

    initial begin
        int k;
        int bad;
        out_t e;

        // ---------------- reset state ----------------
        #3 rst_n = 1'b0;
        #9;
        chk("rst_flags", {60'd0, source_valid, source_sop, source_eop, sink_ready}, 64'd0);
        chk("rst_data",  {32'd0, source_real, source_imag}, 64'd0);
        chk("rst_meta",  {46'd0, source_exp, source_error, fftpts_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_after_reset", {63'd0, sink_ready}, 64'd1);

        // ---------------- basic frame, continuous ready ----------------
        rdy_mode = 0;
        frame_a_in();
        frame_a_exp();
        send_all(12'd4);
        k = 0;
        while (k < 3 && !source_valid) begin
            @(negedge clk);
            k++;
        end
        chk("first_out_latency", {63'd0, source_valid}, 64'd1);
        wait_n(4);
        check_frame("basic");

        // ---------------- full-scale frame: no shift ----------------
        add_in(1'b1, 1'b0, 16'h7FFF, 16'h1234);
        add_in(1'b0, 1'b0, 16'h8000, 16'hFFFF);
        add_in(1'b0, 1'b1, 16'h0005, 16'hFFFA);
        add_exp(1'b1, 1'b0, 16'h7FFF, 16'h1234, 4'd0, 2'b00, 12'd3);
        add_exp(1'b0, 1'b0, 16'h8000, 16'hFFFF, 4'd0, 2'b00, 12'd3);
        add_exp(1'b0, 1'b1, 16'h0005, 16'hFFFA, 4'd0, 2'b00, 12'd3);
        send_all(12'd3);
        wait_n(3);
        check_frame("fullscale");

        // ---------------- basic frame under back-pressure ----------------
        rdy_mode = 1;
        frame_a_in();
        frame_a_exp();
        send_all(12'd4);
        wait_n(4);
        check_frame("stalled");
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- restart: sop inside an open frame ----------------
        add_in(1'b1, 1'b0, 16'h7000, 16'h0000);
        add_in(1'b0, 1'b0, 16'h0001, 16'h0001);
        add_in(1'b0, 1'b0, 16'h0002, 16'h0002);
        send_all(12'd10);
        add_in(1'b1, 1'b0, 16'h0040, 16'h0020);
        add_in(1'b0, 1'b1, 16'hFFC0, 16'h0001);
        add_exp(1'b1, 1'b0, 16'h4000, 16'h2000, 4'd8, 2'b00, 12'd2);
        add_exp(1'b0, 1'b1, 16'hC000, 16'h0100, 4'd8, 2'b00, 12'd2);
        send_all(12'd2);
        wait_n(2);
        check_frame("restart");

        // ---------------- all-zero frame ----------------
        add_in(1'b1, 1'b0, 16'h0000, 16'h0000);
        add_in(1'b0, 1'b1, 16'h0000, 16'h0000);
        add_exp(1'b1, 1'b0, 16'h0000, 16'h0000, 4'd15, 2'b00, 12'd2);
        add_exp(1'b0, 1'b1, 16'h0000, 16'h0000, 4'd15, 2'b00, 12'd2);
        send_all(12'd2);
        wait_n(2);
        check_frame("zeros");

        // ---------------- truncation at buffer size ----------------
        add_in(1'b1, 1'b0, 16'h0001, 16'hFFFF);
        for (int i = 1; i < c_MAXP + 5; i++) begin
            add_in(1'b0, 1'b0, 16'h0001, 16'hFFFF);
        end
        send_all(12'h800);
        wait_n(c_MAXP);
        chk("trunc_count", 64'(got_q.size()), 64'(c_MAXP));
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            e.sop = (i == 0);
            e.eop = (i == c_MAXP - 1);
            e.re  = 16'h4000;
            e.im  = 16'hC000;
            e.ex  = 4'd14;
            e.err = 2'b01;
            e.pts = 12'h800;
            if (got_q[i] !== e) begin
                bad++;
            end
        end
        chk("trunc_bad_samples", 64'(bad), 64'd0);
        if (got_q.size() > 0) begin
            chk("trunc_last_eop_err",
                {61'd0, got_q[got_q.size()-1].eop, got_q[got_q.size()-1].err}, 64'd5);
        end
        chk("trunc_sink_ready_back", {63'd0, sink_ready}, 64'd1);
        got_q.delete();

        // ---------------- reset during drain ----------------
        frame_a_in();
        send_all(12'd4);
        k = 0;
        while (got_q.size() < 2 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("pre_reset_outputs", 64'(got_q.size()), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {60'd0, source_valid, source_sop, source_eop, sink_ready}, 64'd0);
        chk("rst_mid_data",  {32'd0, source_real, source_imag}, 64'd0);
        chk("rst_mid_meta",  {46'd0, source_exp, source_error, fftpts_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        frame_a_in();
        frame_a_exp();
        send_all(12'd4);
        wait_n(4);
        check_frame("after_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ce_block_normalize.md
CE_BLOCK_NORMALIZE -- requirements
Module: ce_block_normalize

Interface
REQ-001 Parameter wData, default 16, sample width of real/imag on both sides (two's complement).
REQ-002 Parameter wAddr, default 11, frame buffer address width; max frame length MAX_PTS = 2^wAddr.
REQ-003 Parameter wExp, default 4, width of the shift exponent; shift capped at SHIFT_MAX = wData-1.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 sink_valid  in  1  input sample valid.
REQ-007 sink_ready  out  1  block accepts a sample when sink_valid & sink_ready.
REQ-008 sink_sop / sink_eop  in  1 each  first / last sample of input frame.
REQ-009 sink_real / sink_imag  in  wData each  input sample.
REQ-010 fftpts_in  in  12  frame length tag, captured on accepted sop.
REQ-011 source_valid  out  1  output sample valid.
REQ-012 source_ready  in  1  downstream ready, ready latency 0.
REQ-013 source_sop / source_eop  out  1 each  first / last sample of output frame.
REQ-014 source_real / source_imag  out  wData each  normalized sample.
REQ-015 source_error  out  2  00 normal, 01 frame truncated at MAX_PTS.
REQ-016 source_exp  out  wExp  left-shift applied to current frame, constant across frame.
REQ-017 fftpts_out  out  12  fftpts_in value captured for current output frame.

Function
REQ-018 FSM states: IDLE, FILL, DRAIN; single-buffered, no input accepted during DRAIN.
REQ-019 IDLE: sink_ready=1; accepted sample without sop is discarded; accepted sop writes addr 0, clears counter and running shift, captures fftpts_in, enters FILL (sop&eop together -> 1-sample frame, go DRAIN).
REQ-020 FILL: sink_ready=1; each accepted sample written at counter address, counter increments.
REQ-021 Per sample, redundant sign bits r = leading bits equal to MSB minus 1, computed for real and imag separately; running shift = min(running shift, r_real, r_imag), initial value SHIFT_MAX.
REQ-022 Accepted eop in FILL: frame length = counter+1, enter DRAIN next cycle.
REQ-023 Accepted sop in FILL (without prior eop): current frame discarded, new frame starts at addr 0 as in REQ-019.
REQ-024 Counter reaching MAX_PTS-1 without eop: that sample treated as eop, frame marked source_error=01.
REQ-025 DRAIN: sink_ready=0; samples read in write order, each output = stored sample << running shift (no overflow possible by construction).
REQ-026 source_sop on first output sample, source_eop on last; source_exp, source_error, fftpts_out constant for whole frame.
REQ-027 Output held stable while source_valid & !source_ready; no sample dropped or duplicated.
REQ-028 First output sample valid no later than 2 cycles after the cycle accepting eop; with source_ready=1 continuous, one sample per cycle.
REQ-029 After eop accepted downstream, return to IDLE next cycle with sink_ready=1.
REQ-030 All-zero frame: shift = SHIFT_MAX, outputs zero, source_exp = SHIFT_MAX.

Reset
REQ-031 rst_n low: state IDLE, counter 0, running shift SHIFT_MAX, source_valid/sop/eop 0, source_real/imag 0, source_error 00, source_exp 0, fftpts_out 0, sink_ready 0 while asserted.
REQ-032 Reset mid-FILL or mid-DRAIN abandons the frame; buffer contents need not be cleared.

Structure
REQ-033 Shared package ce_pkg holds FSM state encoding, SHIFT_MAX and error code constants.
REQ-034 One sub-module ce_frame_ram: simple dual-port RAM, 2^wAddr x 2*wData, 1-cycle registered read.

Verification
REQ-035 4-sample frame {(0x0010,0),(0xFFF0,1),(3,-4),(0,0)}, source_ready=1 -> min r=10, source_exp=10, outputs (0x4000,0),(0xC000,0x0400),(0x0C00,0xF000),(0,0), sop on 1st, eop on 4th.
REQ-036 Frame containing 0x7FFF -> source_exp=0, output equals input bit-exact.
REQ-037 Same 4-sample frame with source_ready toggling 1,0,0,1,... -> identical output sequence, values held during stalls.
REQ-038 2^wAddr+5 samples without eop -> frame of MAX_PTS samples, source_error=01, eop on last; remaining 5 discarded (no sop).
REQ-039 sop, 3 samples, sop again, 2-sample frame with eop -> only 2-sample frame output.
REQ-040 rst_n low during DRAIN sample 2 -> all outputs 0 asynchronously, new frame afterward processed normally.
